// File: rtl/nibble_serial_alu.sv
// Nibble-serial WIDTH-bit ALU: one 4-bit carry-lookahead slice is reused for NIB
// cycles, rippling the carry through a register between nibbles.

module four_bits_CLA (
    input  logic [3:0] ain,
    input  logic [3:0] bin,
    input  logic       cin,
    output logic [3:0] sout,
    output logic       cout,
    output logic       p,
    output logic [3:0] andout,
    output logic [3:0] orout,
    output logic [3:0] xorout
);
    logic [3:0] g;
    logic [3:0] pp;
    logic [4:0] c;

    assign g  = ain & bin;
    assign pp = ain ^ bin;

    // Carries are computed in parallel from generate/propagate terms.
    assign c[0] = cin;
    assign c[1] = g[0] | (pp[0] & cin);
    assign c[2] = g[1] | (pp[1] & g[0]) | (pp[1] & pp[0] & cin);
    assign c[3] = g[2] | (pp[2] & g[1]) | (pp[2] & pp[1] & g[0])
                | (pp[2] & pp[1] & pp[0] & cin);
    assign c[4] = g[3] | (pp[3] & g[2]) | (pp[3] & pp[2] & g[1])
                | (pp[3] & pp[2] & pp[1] & g[0])
                | (pp[3] & pp[2] & pp[1] & pp[0] & cin);

    assign sout   = pp ^ c[3:0];
    assign cout   = c[4];
    assign p      = &pp;
    assign andout = g;
    assign orout  = ain | bin;
    assign xorout = pp;
endmodule

module nibble_serial_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int IW  = CW + 2;

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_alu: WIDTH must be a multiple of 4 and at least 8");
    end

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e           state;
    state_e           state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             cy_q;

    logic             accept;
    logic             last_nib;
    logic             is_arith;
    logic             is_sub;
    logic [IW-1:0]    bit_idx;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             slice_p_unused;
    logic [3:0]       slice_and;
    logic [3:0]       slice_or;
    logic [3:0]       slice_xor;
    logic [3:0]       nib_res;
    logic [WIDTH-1:0] result_nxt;
    logic             ovf_nxt;

    assign accept   = start && (state != S_RUN);
    assign last_nib = (cnt == CW'(NIB - 1));
    assign is_sub   = (op_q == OP_SUB);
    assign is_arith = (op_q == OP_ADD) || is_sub;
    assign bit_idx  = {cnt, 2'b00};
    assign a_nib    = a_q[bit_idx +: 4];
    assign b_nib    = is_sub ? ~b_q[bit_idx +: 4] : b_q[bit_idx +: 4];

    four_bits_CLA u_slice (
        .ain    (a_nib),
        .bin    (b_nib),
        .cin    (cy_q),
        .sout   (slice_sum),
        .cout   (slice_cout),
        .p      (slice_p_unused),
        .andout (slice_and),
        .orout  (slice_or),
        .xorout (slice_xor)
    );

    always_comb begin
        nib_res = 4'b0000;
        case (op_q)
            OP_ADD, OP_SUB: nib_res = slice_sum;
            OP_AND:         nib_res = slice_and;
            OP_OR:          nib_res = slice_or;
            OP_XOR:         nib_res = slice_xor;
            default:        nib_res = 4'b0000;
        endcase
    end

    always_comb begin
        result_nxt                = result;
        result_nxt[bit_idx +: 4]  = nib_res;
    end

    // Signed overflow from the top nibble: equal operand signs, differing sum sign.
    assign ovf_nxt = is_arith & (a_nib[3] ~^ b_nib[3]) & (a_nib[3] ^ slice_sum[3]);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = start ? S_RUN : S_IDLE;
            S_RUN:   state_nxt = last_nib ? S_DONE : S_RUN;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the operand capture registers are reset too; they are a handful of
    // flops, not a memory array, and this keeps post-reset state deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            cnt      <= '0;
            cy_q     <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            cnt  <= '0;
            cy_q <= (op == OP_SUB);
        end else if (state == S_RUN) begin
            result <= result_nxt;
            cy_q   <= slice_cout;
            cnt    <= cnt + CW'(1);
            if (last_nib) begin
                carry    <= is_arith & slice_cout;
                overflow <= ovf_nxt;
                zero     <= (result_nxt == '0);
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_alu.sv
// Directed bench for nibble_serial_alu: latency, arithmetic/logic results, flags,
// back-to-back starts and mid-operation reset.

module tb_nibble_serial_alu;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    int checks;
    int failures;

    nibble_serial_alu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues a one-cycle start, then waits (bounded) for done. Returns at the
    // negedge of the done cycle with the number of busy cycles observed.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int busy_cnt, output bit seen);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, result, carry, overflow, zero} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b result=%h c=%b v=%b z=%b want all 0",
                     busy, done, result, carry, overflow, zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_add_wrap;
        int  bc;
        bit  seen;
        run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, bc, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL add_wrap_timeout got no done want done");
        end
        checks++;
        if (bc != 8) begin
            failures++;
            $display("FAIL add_wrap_busy_cycles got %0d want 8", bc);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL add_wrap_busy_in_done got %b want 0", busy);
        end
        checks++;
        if ({result, carry, overflow, zero} !== {32'h0000_0000, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL add_wrap got r=%h c=%b v=%b z=%b want r=00000000 c=1 v=0 z=1",
                     result, carry, overflow, zero);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL add_wrap_done_pulse got busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if ({result, carry, zero} !== {32'h0000_0000, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL add_wrap_hold got r=%h c=%b z=%b want 00000000 1 1", result, carry, zero);
        end
    endtask

    task automatic test_sub;
        int bc;
        bit seen;
        run_op(3'b001, 32'd5, 32'd7, bc, seen);
        checks++;
        if (!seen || {result, carry, overflow, zero} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL sub_5_7 got done=%b r=%h c=%b v=%b z=%b want r=fffffffe c=0 v=0 z=0",
                     seen, result, carry, overflow, zero);
        end
        run_op(3'b001, 32'd7, 32'd7, bc, seen);
        checks++;
        if (!seen || {result, carry, overflow, zero} !== {32'h0000_0000, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL sub_7_7 got done=%b r=%h c=%b v=%b z=%b want r=00000000 c=1 v=0 z=1",
                     seen, result, carry, overflow, zero);
        end
    endtask

    task automatic test_overflow;
        int bc;
        bit seen;
        run_op(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, bc, seen);
        checks++;
        if (!seen || {result, carry, overflow, zero} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL add_ovf got done=%b r=%h c=%b v=%b z=%b want r=80000000 c=0 v=1 z=0",
                     seen, result, carry, overflow, zero);
        end
        run_op(3'b001, 32'h8000_0000, 32'h0000_0001, bc, seen);
        checks++;
        if (!seen || {result, carry, overflow, zero} !== {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sub_ovf got done=%b r=%h c=%b v=%b z=%b want r=7fffffff c=1 v=1 z=0",
                     seen, result, carry, overflow, zero);
        end
    endtask

    task automatic test_logic;
        logic [2:0]  ops  [5];
        logic [31:0] exps [5];
        int bc;
        bit seen;
        ops[0] = 3'b010; exps[0] = 32'h00F0_1234;
        ops[1] = 3'b011; exps[1] = 32'hFFF0_FFFF;
        ops[2] = 3'b100; exps[2] = 32'hFF00_EDCB;
        ops[3] = 3'b111; exps[3] = 32'h0000_0000;
        ops[4] = 3'b101; exps[4] = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            // A carry-producing ADD first so stale carry/zero flags would show.
            run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, bc, seen);
            run_op(ops[i], 32'hF0F0_1234, 32'h0FF0_FFFF, bc, seen);
            checks++;
            if (!seen || {result, carry, overflow, zero} !== {exps[i], 1'b0, 1'b0, exps[i] == 32'h0}) begin
                failures++;
                $display("FAIL logic_op%0d got done=%b r=%h c=%b v=%b z=%b want r=%h c=0 v=0 z=%b",
                         ops[i], seen, result, carry, overflow, zero, exps[i], exps[i] == 32'h0);
            end
        end
    endtask

    task automatic test_back_to_back;
        int  dones;
        bit  seen;
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd10; b = 32'd20;
        @(negedge clk);
        // Operands change while start stays high; the running op must ignore them.
        op = 3'b001; a = 32'd100; b = 32'd200;
        dones = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) begin
                dones++;
                seen = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!seen || dones != 1 || result !== 32'd30) begin
            failures++;
            $display("FAIL b2b_first got done=%b count=%0d r=%h want 1 1 0000001e", seen, dones, result);
        end
        op = 3'b000; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_no_gap got busy=%b done=%b want 1 0", busy, done);
        end
        seen = 1'b0;
        dones = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || {result, carry, zero} !== {32'd11, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_second got done=%b r=%h c=%b z=%b want 1 0000000b 0 0",
                     seen, result, carry, zero);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL b2b_extra_done got %0d extra pulses want 0", dones);
        end
    endtask

    task automatic test_reset_abort;
        int dones;
        int bc;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'h1234_5678; b = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, carry, overflow, zero} !== '0) begin
            failures++;
            $display("FAIL abort_outputs got busy=%b done=%b r=%h c=%b v=%b z=%b want all 0",
                     busy, done, result, carry, overflow, zero);
        end
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL abort_no_done got %0d busy/done cycles want 0", dones);
        end
        run_op(3'b000, 32'd3, 32'd4, bc, seen);
        checks++;
        if (!seen || bc != 8 || {result, carry, overflow, zero} !== {32'd7, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL abort_recover got done=%b busy=%0d r=%h c=%b v=%b z=%b want 1 8 00000007 0 0 0",
                     seen, bc, result, carry, overflow, zero);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add_wrap();
        test_sub();
        test_overflow();
        test_logic();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
